// File: rtl/uart_tx_word_fifo.sv
// Word FIFO feeding a byte-wide UART sender: 32-bit words are queued and sent MSB byte first.
// Optional drop accounting (overflow, drop_count) is built when UART_TX_DROP_COUNT_EN is defined.
module uart_tx_word_fifo #(
  parameter int DEPTH_WIDTH = 3
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  input  logic        sender_ready,
  output logic [7:0]  sender_data,
  output logic        sender_enable,
  output logic        full,
  output logic        empty,
  output logic        busy
`ifdef UART_TX_DROP_COUNT_EN
  ,
  output logic        overflow,
  output logic [15:0] drop_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] LP_DEPTH = (DEPTH_WIDTH+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [31:0]            r_mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_WIDTH:0]   r_count;
  logic                   r_full, r_empty;
  logic [1:0]             r_state;
  logic [31:0]            r_shreg;
  logic [1:0]             r_byte_idx;
  logic [7:0]             r_sender_data;
  logic                   r_sender_enable;

  logic                   w_push, w_pop, w_drop;
  logic [DEPTH_WIDTH:0]   w_count_nxt;

  // Full is checked before any same-edge pop, so a push into a full FIFO is always dropped.
  assign w_push      = word_valid && !r_full;
  assign w_drop      = word_valid &&  r_full;
  assign w_pop       = (r_state == ST_IDLE) && !r_empty;
  assign w_count_nxt = r_count + {{DEPTH_WIDTH{1'b0}}, w_push} - {{DEPTH_WIDTH{1'b0}}, w_pop};

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= word_in;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_WIDTH'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LP_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_shreg         <= '0;
      r_byte_idx      <= '0;
      r_sender_data   <= '0;
      r_sender_enable <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_empty) begin
            r_shreg    <= r_mem[r_rd_ptr];
            r_byte_idx <= '0;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (sender_ready) begin
            r_sender_data   <= r_shreg[31:24];
            r_sender_enable <= 1'b1;
            r_state         <= ST_GUARD;
          end
        end
        // Ready is ignored here: the sender needs a cycle to drop it after the start pulse.
        ST_GUARD: begin
          r_sender_enable <= 1'b0;
          r_state         <= ST_WAIT;
        end
        default: begin
          if (sender_ready) begin
            if (r_byte_idx == 2'd3) begin
              r_state <= ST_IDLE;
            end else begin
              r_shreg    <= {r_shreg[23:0], 8'h00};
              r_byte_idx <= r_byte_idx + 2'd1;
              r_state    <= ST_SEND;
            end
          end
        end
      endcase
    end
  end

`ifdef UART_TX_DROP_COUNT_EN
  logic        r_overflow;
  logic [15:0] r_drop_count;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

  assign sender_data   = r_sender_data;
  assign sender_enable = r_sender_enable;
  assign full          = r_full;
  assign empty         = r_empty;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// Directed bench for uart_tx_word_fifo: latency, ordering, pacing, overflow and reset behaviour.
module tb_uart_tx_word_fifo;
  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        sender_ready = 1'b1;
  logic [7:0]  sender_data;
  logic        sender_enable, full, empty, busy;
`ifdef UART_TX_DROP_COUNT_EN
  logic        overflow;
  logic [15:0] drop_count;
`endif

  uart_tx_word_fifo #(.DEPTH_WIDTH(3)) dut (
    .CLK(CLK), .reset_n(reset_n), .word_in(word_in), .word_valid(word_valid),
    .sender_ready(sender_ready), .sender_data(sender_data), .sender_enable(sender_enable),
    .full(full), .empty(empty), .busy(busy)
`ifdef UART_TX_DROP_COUNT_EN
    , .overflow(overflow), .drop_count(drop_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Byte j of test word k: k + 0x40*j, so every byte of every word is distinct.
  function automatic logic [7:0] exp_byte(input int k, input int j);
    return 8'(k) + 8'(64 * j);
  endfunction

  function automatic logic [31:0] wordk(input int k);
    return {exp_byte(k, 0), exp_byte(k, 1), exp_byte(k, 2), exp_byte(k, 3)};
  endfunction

  logic [7:0] rx_q[$];
  bit         model_en = 1'b0;
  int         ready_cnt = 0;
  logic       ready_at_edge = 1'b1;
  logic       prev_en = 1'b0;

  always @(posedge CLK) ready_at_edge = sender_ready;

  // Byte collector plus optional sender model that stays busy 10 cycles after each start pulse.
  always @(negedge CLK) begin
    if (sender_enable) begin
      rx_q.push_back(sender_data);
      chk("en_while_not_ready", 32'(ready_at_edge), 32'd1);
      chk("en_two_cycles", 32'(prev_en), 32'd0);
    end
    prev_en = sender_enable;
    if (model_en) begin
      if (sender_enable) begin
        ready_cnt    = 10;
        sender_ready = 1'b0;
      end else if (ready_cnt > 0) begin
        ready_cnt--;
        if (ready_cnt == 0) sender_ready = 1'b1;
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    word_in    = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (rx_q.size() < n) chk("timeout_rx", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((busy || !empty) && c < budget) begin
      tick();
      c++;
    end
    if (busy || !empty) chk("timeout_idle", 32'(busy), 32'd0);
  endtask

  task automatic chk_words(input string tag, input int first_idx, input int first_id, input int nwords);
    for (int w = 0; w < nwords; w++)
      for (int j = 0; j < 4; j++)
        chk(tag, 32'(rx_q[first_idx + 4*w + j]), 32'(exp_byte(first_id + w, j)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    int n0;
    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(sender_enable), 32'd0);
    chk("rst_data", 32'(sender_data), 32'd0);
    reset_n = 1'b1;
    tick();

    // Latency and MSB-first order for DEADBEEF with ready tied high
    rx_q.delete();
    word_in = 32'hDEADBEEF;
    word_valid = 1'b1;
    tick();                       // E0
    word_valid = 1'b0;
    chk("lat_e0_en", 32'(sender_enable), 32'd0);
    tick();                       // E1: pop
    chk("lat_e1_en", 32'(sender_enable), 32'd0);
    chk("lat_e1_busy", 32'(busy), 32'd1);
    tick();                       // E2: first pulse
    chk("lat_e2_en", 32'(sender_enable), 32'd1);
    chk("lat_e2_data", 32'(sender_data), 32'h0000_00DE);
    wait_rx(4, 50);
    chk("dead_b0", 32'(rx_q[0]), 32'h0000_00DE);
    chk("dead_b1", 32'(rx_q[1]), 32'h0000_00AD);
    chk("dead_b2", 32'(rx_q[2]), 32'h0000_00BE);
    chk("dead_b3", 32'(rx_q[3]), 32'h0000_00EF);
    wait_idle(50);

    // Reset asserted while in GUARD
    rx_q.delete();
    push(32'h12345678);
    c = 0;
    while (!sender_enable && c < 20) begin
      tick();
      c++;
    end
    chk("rstmid_reach_guard", 32'(sender_enable), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstmid_en", 32'(sender_enable), 32'd0);
    chk("rstmid_empty", 32'(empty), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    n0 = rx_q.size();
    @(negedge CLK);
    reset_n = 1'b1;
    repeat (20) tick();
    chk("rstmid_no_bytes", 32'(rx_q.size()), 32'(n0));
    chk("rstmid_empty2", 32'(empty), 32'd1);

    // Paced sender, three words back to back
    rx_q.delete();
    model_en = 1'b1;
    push(wordk(1));
    push(wordk(2));
    push(wordk(3));
    wait_rx(12, 600);
    chk_words("paced_byte", 0, 1, 3);
    model_en = 1'b0;
    sender_ready = 1'b1;
    wait_idle(100);

    // Fill with ready low: word 0 held in the shift register, words 1..8 fill the FIFO
    rx_q.delete();
    sender_ready = 1'b0;
    for (int k = 0; k <= 8; k++) push(wordk(k));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);
    chk("fill_busy", 32'(busy), 32'd1);
    push(32'hBAD0BAD0);
    chk("drop_full", 32'(full), 32'd1);
    chk("drop_no_bytes", 32'(rx_q.size()), 32'd0);
`ifdef UART_TX_DROP_COUNT_EN
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_count1", 32'(drop_count), 32'd1);
`endif

    // Pop and push on the same edge while full: push is dropped, then refill with wrap
    sender_ready = 1'b1;
    c = 0;
    while (!(!busy && !empty) && c < 100) begin
      tick();
      c++;
    end
    chk("samedge_idle_full", 32'(full), 32'd1);
    word_in = 32'hBAD1BAD1;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    chk("samedge_cnt7", 32'(full), 32'd0);
    chk("samedge_busy", 32'(busy), 32'd1);
    push(wordk(9));
    chk("samedge_cnt8", 32'(full), 32'd1);
    for (int k = 10; k <= 15; k++) begin
      c = 0;
      while (full && c < 100) begin
        tick();
        c++;
      end
      chk("wrap_space", 32'(full), 32'd0);
      push(wordk(k));
    end
    wait_rx(64, 2000);
    chk_words("wrap_byte", 0, 0, 16);
`ifdef UART_TX_DROP_COUNT_EN
    chk("drop_count2", 32'(drop_count), 32'd2);
`endif
    wait_idle(100);

    // Push during WAIT on the last byte: popped on the following edge
    rx_q.delete();
    push(wordk(20));
    wait_rx(4, 50);
    tick();                       // GUARD -> WAIT
    word_in = wordk(21);
    word_valid = 1'b1;
    tick();                       // WAIT -> IDLE, push lands
    word_valid = 1'b0;
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_empty", 32'(empty), 32'd0);
    tick();                       // pop
    chk("b2b_pop_busy", 32'(busy), 32'd1);
    chk("b2b_pop_empty", 32'(empty), 32'd1);
    tick();                       // first byte of next word
    chk("b2b_en", 32'(sender_enable), 32'd1);
    chk("b2b_data", 32'(sender_data), 32'(exp_byte(21, 0)));
    wait_rx(8, 50);
    chk_words("b2b_byte", 0, 20, 2);
    wait_idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
